// File: rtl/rom_load_pkg.sv
// Shared types, default ioctl indices and the window-match helper for the
// ROM download router.
package rom_load_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, HOLD} load_state_e;

   localparam logic [7:0] ROM_INDEX_DEF = 8'd0;
   localparam logic [7:0] MOD_INDEX_DEF = 8'd1;
   localparam logic [7:0] DIP_INDEX_DEF = 8'd254;

   // 17-bit compare so a window ending exactly at 0x10000 does not wrap to 0.
   function automatic logic rgn_hit(input logic [15:0] addr,
                                    input logic [15:0] base,
                                    input logic [4:0]  aw);
      logic [16:0] lo;
      logic [16:0] hi;
      lo = {1'b0, base};
      hi = lo + (17'd1 << aw);
      return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
   endfunction

endpackage

// File: rtl/rom_region_decode.sv
// One ROM address window: qualifies a ROM write against [BASE, BASE+2^AW)
// and produces the region-relative byte offset.
module rom_region_decode
   import rom_load_pkg::*;
#(
   parameter logic [15:0] BASE   = 16'h0000,
   parameter logic [4:0]  AW     = 5'd16,
   parameter int          MAX_AW = 16
) (
   input  logic              rom_wr,
   input  logic [15:0]       addr,
   output logic              hit,
   output logic [MAX_AW-1:0] offset
);

   logic [15:0] diff;

   assign diff   = addr - BASE;
   assign hit    = rom_wr & rgn_hit(addr, BASE, AW);
   assign offset = MAX_AW'(diff);

endmodule

// File: rtl/rom_load_router.sv
// Routes hps_io ioctl download bytes to ROM region write strobes, DIP bytes and
// a variant select, and sequences core reset around each ROM load.
module rom_load_router
   import rom_load_pkg::*;
#(
   parameter int                        NUM_REGIONS = 4,
   parameter int                        MAX_AW      = 16,
   parameter logic [NUM_REGIONS*16-1:0] REGION_BASE = {16'hFF00, 16'hE000, 16'h0000, 16'h0000},
   parameter logic [NUM_REGIONS*5-1:0]  REGION_AW   = {5'd16, 5'd12, 5'd16, 5'd15},
   parameter logic [7:0]                ROM_INDEX   = ROM_INDEX_DEF,
   parameter logic [7:0]                MOD_INDEX   = MOD_INDEX_DEF,
   parameter logic [7:0]                DIP_INDEX   = DIP_INDEX_DEF,
   parameter int                        NUM_MODS    = 5,
   parameter int                        HOLD_CYCLES = 256,
   parameter logic [63:0]               DIP_DEFAULT = 64'h0
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic                   ioctl_download,
   input  logic                   ioctl_wr,
   input  logic [24:0]            ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   input  logic [7:0]             ioctl_index,
   output logic [NUM_REGIONS-1:0] rgn_we,
   output logic [MAX_AW-1:0]      rgn_addr,
   output logic [7:0]             rgn_data,
   output logic [63:0]            dip_sw,
   output logic [NUM_MODS-1:0]    mod_sel,
   output logic                   core_reset_n,
   output logic                   load_busy,
   output logic                   load_done,
   output logic [24:0]            byte_count,
   output logic [15:0]            checksum
);

   localparam int         CW       = $clog2(HOLD_CYCLES + 1);
   localparam logic [8:0] MODS_LIM = 9'(NUM_MODS);

   load_state_e state, next_state;
   logic [CW-1:0] cnt, cnt_next;
   logic          start_load, hold_done;
   logic          core_reset_n_d, load_busy_d;

   logic rom_req, rom_wr, dip_wr, mod_wr;
   logic [NUM_REGIONS-1:0] hit;
   logic [MAX_AW-1:0]      offset [NUM_REGIONS];
   logic [MAX_AW-1:0]      sel_offset;

   assign rom_req = ioctl_download & (ioctl_index == ROM_INDEX);
   assign rom_wr  = ioctl_wr & rom_req & (ioctl_addr[24:16] == '0);
   assign dip_wr  = ioctl_wr & (ioctl_index == DIP_INDEX) & (ioctl_addr[24:3] == '0);
   assign mod_wr  = ioctl_wr & (ioctl_index == MOD_INDEX);

   for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_rgn
      rom_region_decode #(
         .BASE   (REGION_BASE[i*16 +: 16]),
         .AW     (REGION_AW[i*5 +: 5]),
         .MAX_AW (MAX_AW)
      ) u_decode (
         .rom_wr (rom_wr),
         .addr   (ioctl_addr[15:0]),
         .hit    (hit[i]),
         .offset (offset[i])
      );
   end

   // Overlapping windows all strobe; the offset comes from the lowest-numbered hit.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      sel_offset = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (hit[i]) sel_offset = offset[i];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= HOLD;
         cnt   <= CW'(HOLD_CYCLES - 1);
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      start_load = 1'b0;
      hold_done  = 1'b0;
      if (rom_req) begin
         next_state = LOAD;
         start_load = (state != LOAD);
      end else begin
         case (state)
            LOAD: if (!ioctl_download) begin
               next_state = HOLD;
               cnt_next   = CW'(HOLD_CYCLES - 1);
            end
            HOLD: if (cnt == '0) begin
               next_state = IDLE;
               hold_done  = 1'b1;
            end else begin
               cnt_next = cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      core_reset_n_d = (next_state == IDLE);
      load_busy_d    = (next_state != IDLE);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         core_reset_n <= 1'b0;
         load_busy    <= 1'b1;
         load_done    <= 1'b0;
         byte_count   <= '0;
         checksum     <= '0;
      end else begin
         core_reset_n <= core_reset_n_d;
         load_busy    <= load_busy_d;
         if (start_load)     load_done <= 1'b0;
         else if (hold_done) load_done <= 1'b1;
         // A write landing on the entry cycle is the first byte of the new load.
         if (start_load) begin
            byte_count <= rom_wr ? 25'd1 : 25'd0;
            checksum   <= rom_wr ? {8'd0, ioctl_dout} : 16'd0;
         end else if (rom_wr) begin
            if (byte_count != '1) byte_count <= byte_count + 25'd1;
            checksum <= checksum + {8'd0, ioctl_dout};
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rgn_we   <= '0;
         rgn_addr <= '0;
         rgn_data <= '0;
         dip_sw   <= DIP_DEFAULT;
         mod_sel  <= NUM_MODS'(1);
      end else begin
         rgn_we <= hit;
         if (|hit)  rgn_addr <= sel_offset;
         if (rom_wr) rgn_data <= ioctl_dout;
         if (dip_wr) dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
         if (mod_wr) mod_sel <= ({1'b0, ioctl_dout} < MODS_LIM) ? (NUM_MODS'(1) << ioctl_dout) : '0;
      end
   end

endmodule

// File: tb/tb_rom_load_router.sv
// Randomised self-checking bench for rom_load_router against a behavioural
// model of the download windows, counters, DIP/variant bytes and load sequence.
module tb_rom_load_router;

   localparam int          NR   = 4;
   localparam int          MAW  = 16;
   localparam logic [63:0] RB   = {16'hFF00, 16'hE000, 16'h0000, 16'h0000};
   localparam logic [19:0] RAW  = {5'd16, 5'd12, 5'd16, 5'd15};
   localparam logic [7:0]  ROMI = 8'd0;
   localparam logic [7:0]  MODI = 8'd1;
   localparam logic [7:0]  DIPI = 8'd254;
   localparam int          NM   = 5;
   localparam int          HOLD = 256;
   localparam logic [63:0] DIPD = 64'h0;

   logic           clk_sys = 1'b0;
   logic           reset_n = 1'b1;
   logic           ioctl_download = 1'b0;
   logic           ioctl_wr = 1'b0;
   logic [24:0]    ioctl_addr = '0;
   logic [7:0]     ioctl_dout = '0;
   logic [7:0]     ioctl_index = '0;
   logic [NR-1:0]  rgn_we;
   logic [MAW-1:0] rgn_addr;
   logic [7:0]     rgn_data;
   logic [63:0]    dip_sw;
   logic [NM-1:0]  mod_sel;
   logic           core_reset_n, load_busy, load_done;
   logic [24:0]    byte_count;
   logic [15:0]    checksum;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [NR-1:0]  exp_we;
   logic [MAW-1:0] exp_raddr;
   logic [7:0]     exp_rdata;
   logic [63:0]    exp_dip;
   logic [NM-1:0]  exp_mod;
   logic [24:0]    exp_count;
   logic [15:0]    exp_sum;
   bit             in_load;

   rom_load_router #(
      .NUM_REGIONS (NR), .MAX_AW (MAW), .REGION_BASE (RB), .REGION_AW (RAW),
      .ROM_INDEX (ROMI), .MOD_INDEX (MODI), .DIP_INDEX (DIPI),
      .NUM_MODS (NM), .HOLD_CYCLES (HOLD), .DIP_DEFAULT (DIPD)
   ) dut (
      .clk_sys (clk_sys), .reset_n (reset_n),
      .ioctl_download (ioctl_download), .ioctl_wr (ioctl_wr),
      .ioctl_addr (ioctl_addr), .ioctl_dout (ioctl_dout), .ioctl_index (ioctl_index),
      .rgn_we (rgn_we), .rgn_addr (rgn_addr), .rgn_data (rgn_data),
      .dip_sw (dip_sw), .mod_sel (mod_sel), .core_reset_n (core_reset_n),
      .load_busy (load_busy), .load_done (load_done),
      .byte_count (byte_count), .checksum (checksum)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   function automatic void model_reset();
      exp_we = '0; exp_raddr = '0; exp_rdata = '0;
      exp_dip = DIPD; exp_mod = NM'(1);
      exp_count = '0; exp_sum = '0; in_load = 0;
   endfunction

   // Region i covers byte addresses base_i .. base_i + 2^aw_i - 1.
   function automatic void model_rom(input logic [15:0] a, input logic [7:0] d);
      bit first = 1;
      exp_we = '0;
      for (int i = 0; i < NR; i++) begin
         int b = int'(RB[i*16 +: 16]);
         int w = int'(RAW[i*5 +: 5]);
         if (int'(a) >= b && int'(a) < b + (1 << w)) begin
            exp_we[i] = 1'b1;
            if (first) exp_raddr = MAW'(int'(a) - b);
            first = 0;
         end
      end
      exp_rdata = d;
      if (exp_count != '1) exp_count = exp_count + 1;
      exp_sum = exp_sum + 16'(d);
   endfunction

   task automatic do_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
      ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
      exp_we = '0;
      if (ioctl_download && idx == ROMI && a[24:16] == 0) model_rom(a[15:0], d);
      if (idx == DIPI && a < 25'd8) exp_dip[int'(a)*8 +: 8] = d;
      if (idx == MODI) exp_mod = (d < NM) ? NM'(1) << d : '0;
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic begin_load();
      ioctl_index = ROMI; ioctl_download = 1'b1;
      if (!in_load) begin exp_count = '0; exp_sum = '0; end
      in_load = 1;
      tick();
   endtask

   task automatic end_load();
      ioctl_download = 1'b0; ioctl_wr = 1'b0; in_load = 0;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (load_busy && cycles < 2000);
   endtask

   task automatic test_reset();
      int n;
      model_reset();
      #2 reset_n = 1'b0;
      #2;
      checks++;
      if ({core_reset_n, load_busy, load_done, rgn_we, rgn_addr, rgn_data} !== {1'b0, 1'b1, 1'b0, 4'b0, 16'b0, 8'b0}) begin
         errors++;
         $display("FAIL reset_ctrl: got rst_n=%b busy=%b done=%b we=%b addr=%h data=%h, want 0 1 0 0 0 0",
                  core_reset_n, load_busy, load_done, rgn_we, rgn_addr, rgn_data);
      end
      checks++;
      if (dip_sw !== exp_dip || mod_sel !== exp_mod || byte_count !== 25'd0 || checksum !== 16'd0) begin
         errors++;
         $display("FAIL reset_regs: got dip=%h mod=%b cnt=%0d sum=%h, want dip=%h mod=%b cnt=0 sum=0",
                  dip_sw, mod_sel, byte_count, checksum, exp_dip, exp_mod);
      end
      repeat (3) tick();
      reset_n = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!core_reset_n && n < 400);
      checks++;
      if (n != HOLD) begin
         errors++;
         $display("FAIL reset_hold_len: core_reset_n rose after %0d cycles, want %0d", n, HOLD);
      end
      checks++;
      if ({load_done, load_busy, mod_sel, dip_sw} !== {1'b1, 1'b0, exp_mod, exp_dip}) begin
         errors++;
         $display("FAIL reset_end_state: got done=%b busy=%b mod=%b dip=%h, want 1 0 %b %h",
                  load_done, load_busy, mod_sel, dip_sw, exp_mod, exp_dip);
      end
   endtask

   task automatic test_windows();
      logic [15:0] dir_a [4] = '{16'h0010, 16'hE005, 16'hFF01, 16'h8000};
      logic [7:0]  dir_d [4] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};
      int cyc;
      begin_load();
      checks++;
      if ({load_busy, core_reset_n, load_done, byte_count, checksum} !== {1'b1, 1'b0, 1'b0, 25'd0, 16'd0}) begin
         errors++;
         $display("FAIL load_entry: got busy=%b rst_n=%b done=%b cnt=%0d sum=%h, want 1 0 0 0 0",
                  load_busy, core_reset_n, load_done, byte_count, checksum);
      end
      for (int i = 0; i < 4; i++) begin
         do_write(ROMI, {9'd0, dir_a[i]}, dir_d[i]);
         checks++;
         if (rgn_we !== exp_we || rgn_addr !== exp_raddr || rgn_data !== exp_rdata) begin
            errors++;
            $display("FAIL window_%h: got we=%b addr=%h data=%h, want we=%b addr=%h data=%h",
                     dir_a[i], rgn_we, rgn_addr, rgn_data, exp_we, exp_raddr, exp_rdata);
         end
      end
      tick();
      checks++;
      if (rgn_we !== '0) begin
         errors++;
         $display("FAIL we_pulse: got we=%b one cycle after strobe, want 0000", rgn_we);
      end
      for (int i = 0; i < 40; i++) begin
         logic [7:0]  idx = ($urandom_range(0, 4) == 0) ? 8'd2 : ROMI;
         logic [24:0] a   = ($urandom_range(0, 4) == 0) ? 25'($urandom) : {9'd0, 16'($urandom)};
         do_write(idx, a, 8'($urandom));
         checks++;
         if (rgn_we !== exp_we || rgn_addr !== exp_raddr || (exp_we != 0 && rgn_data !== exp_rdata)) begin
            errors++;
            $display("FAIL rand_window idx=%0d addr=%h: got we=%b addr=%h data=%h, want we=%b addr=%h data=%h",
                     idx, a, rgn_we, rgn_addr, rgn_data, exp_we, exp_raddr, exp_rdata);
         end
         repeat ($urandom_range(0, 2)) tick();
      end
      ioctl_index = ROMI;
      checks++;
      if (byte_count !== exp_count || checksum !== exp_sum || load_busy !== 1'b1) begin
         errors++;
         $display("FAIL load_totals: got cnt=%0d sum=%h busy=%b, want cnt=%0d sum=%h busy=1",
                  byte_count, checksum, load_busy, exp_count, exp_sum);
      end
      end_load();
      wait_idle(cyc);
      // One edge for LOAD->HOLD, then HOLD_CYCLES cycles of hold.
      checks++;
      if (cyc != HOLD + 1 || load_done !== 1'b1 || core_reset_n !== 1'b1) begin
         errors++;
         $display("FAIL hold_after_load: busy for %0d cycles done=%b rst_n=%b, want %0d 1 1",
                  cyc, load_done, core_reset_n, HOLD + 1);
      end
   endtask

   task automatic test_full_load();
      int cyc;
      begin_load();
      for (int a = 0; a < 65536; a++) begin
         do_write(ROMI, 25'(a), 8'(a));
         if (a % 8192 == 8191) begin
            checks++;
            if (rgn_we !== exp_we || rgn_addr !== exp_raddr) begin
               errors++;
               $display("FAIL full_load_we addr=%h: got we=%b addr=%h, want we=%b addr=%h",
                        a, rgn_we, rgn_addr, exp_we, exp_raddr);
            end
         end
      end
      end_load();
      tick();
      checks++;
      if (byte_count !== exp_count || checksum !== exp_sum) begin
         errors++;
         $display("FAIL full_load_totals: got cnt=%0d sum=%h, want cnt=%0d sum=%h",
                  byte_count, checksum, exp_count, exp_sum);
      end
      wait_idle(cyc);
      checks++;
      if (cyc != HOLD || load_done !== 1'b1) begin
         errors++;
         $display("FAIL full_load_hold: busy %0d more cycles done=%b, want %0d 1", cyc, load_done, HOLD);
      end
   endtask

   task automatic test_dip_mod();
      do_write(DIPI, 25'd0, 8'h80);
      do_write(DIPI, 25'd9, 8'h3C);
      checks++;
      if (dip_sw !== exp_dip || load_busy !== 1'b0 || core_reset_n !== 1'b1) begin
         errors++;
         $display("FAIL dip_directed: got dip=%h busy=%b rst_n=%b, want dip=%h 0 1",
                  dip_sw, load_busy, core_reset_n, exp_dip);
      end
      for (int i = 0; i < 12; i++) begin
         logic [24:0] a = 25'($urandom_range(0, 15));
         do_write(DIPI, a, 8'($urandom));
         checks++;
         if (dip_sw !== exp_dip) begin
            errors++;
            $display("FAIL dip_rand addr=%0d: got dip=%h, want %h", a, dip_sw, exp_dip);
         end
      end
      do_write(MODI, 25'd0, 8'h02);
      checks++;
      if (mod_sel !== exp_mod) begin
         errors++;
         $display("FAIL mod_2: got %b, want %b", mod_sel, exp_mod);
      end
      do_write(MODI, 25'd0, 8'h07);
      checks++;
      if (mod_sel !== exp_mod) begin
         errors++;
         $display("FAIL mod_7: got %b, want %b", mod_sel, exp_mod);
      end
      for (int i = 0; i < 10; i++) begin
         logic [7:0] v = 8'($urandom_range(0, 9));
         do_write(MODI, 25'($urandom), v);
         checks++;
         if (mod_sel !== exp_mod) begin
            errors++;
            $display("FAIL mod_rand val=%0d: got %b, want %b", v, mod_sel, exp_mod);
         end
      end
      checks++;
      if (load_busy !== 1'b0 || byte_count !== exp_count || rgn_we !== '0) begin
         errors++;
         $display("FAIL side_effects: got busy=%b cnt=%0d we=%b, want 0 %0d 0000",
                  load_busy, byte_count, rgn_we, exp_count);
      end
   endtask

   task automatic test_restart();
      int bad = 0;
      int cyc;
      begin_load();
      for (int i = 0; i < 10; i++) do_write(ROMI, {9'd0, 16'($urandom)}, 8'($urandom));
      end_load();
      for (int i = 0; i < 100; i++) begin
         tick();
         if (core_reset_n !== 1'b0 || load_busy !== 1'b1) bad++;
      end
      begin_load();
      if (core_reset_n !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL restart_reset_low: %0d cycles with core_reset_n high or idle, want 0", bad);
      end
      checks++;
      if ({byte_count, checksum, load_done} !== {25'd0, 16'd0, 1'b0}) begin
         errors++;
         $display("FAIL restart_clear: got cnt=%0d sum=%h done=%b, want 0 0 0", byte_count, checksum, load_done);
      end
      for (int i = 0; i < 6; i++) do_write(ROMI, {9'd0, 16'($urandom)}, 8'($urandom));
      end_load();
      wait_idle(cyc);
      checks++;
      if (cyc != HOLD + 1 || byte_count !== exp_count || checksum !== exp_sum || load_done !== 1'b1) begin
         errors++;
         $display("FAIL restart_finish: busy %0d cnt=%0d sum=%h done=%b, want %0d %0d %h 1",
                  cyc, byte_count, checksum, load_done, HOLD + 1, exp_count, exp_sum);
      end
   endtask

   task automatic test_async_reset();
      int cyc;
      begin_load();
      for (int i = 0; i < 5; i++) do_write(ROMI, {9'd0, 16'($urandom)}, 8'($urandom | 8'h01));
      end_load();
      ioctl_download = 1'b1;
      #2 reset_n = 1'b0;
      ioctl_download = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({core_reset_n, load_busy, load_done, rgn_we, rgn_addr, rgn_data, byte_count, checksum}
          !== {1'b0, 1'b1, 1'b0, 4'b0, 16'b0, 8'b0, 25'b0, 16'b0}) begin
         errors++;
         $display("FAIL async_reset_ctrl: got rst_n=%b busy=%b done=%b we=%b addr=%h data=%h cnt=%0d sum=%h, want all reset",
                  core_reset_n, load_busy, load_done, rgn_we, rgn_addr, rgn_data, byte_count, checksum);
      end
      checks++;
      if (dip_sw !== exp_dip || mod_sel !== exp_mod) begin
         errors++;
         $display("FAIL async_reset_regs: got dip=%h mod=%b, want %h %b", dip_sw, mod_sel, exp_dip, exp_mod);
      end
      repeat (2) tick();
      reset_n = 1'b1;
      wait_idle(cyc);
      checks++;
      if (cyc != HOLD || load_done !== 1'b1 || core_reset_n !== 1'b1) begin
         errors++;
         $display("FAIL async_reset_hold: busy %0d done=%b rst_n=%b, want %0d 1 1", cyc, load_done, core_reset_n, HOLD);
      end
   endtask

   initial begin
      test_reset();
      test_windows();
      test_dip_mod();
      test_restart();
      test_async_reset();
      test_full_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
